banked_dlrom: RTL and testbench

BANKED_DLROM -- requirements
Module: banked_dlrom

---
 rtl/banked_dlrom.sv | 168 ++++++++++++++++
 tb/tb_banked_dlrom.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_dlrom.sv
// Banked download ROM: bytes streamed in over a download port are packed little-endian into
// DW-bit words and written into NB banks; the CPU side reads with one cycle of latency.
module banked_dlrom #(
  parameter int unsigned AW    = 13,
  parameter int unsigned DW    = 8,
  parameter int unsigned NB    = 3,
  parameter int unsigned FIRST = 5,
  parameter logic [17:0] BASE  = 18'h00000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW+2:0] ad,
  output logic [DW-1:0] dt,
  input  logic [17:0]   dl_ad,
  input  logic [7:0]    dl_dt,
  input  logic          dl_en,
  output logic          dl_err,
  output logic [15:0]   dl_sum,
  output logic [15:0]   dl_words
);

  localparam int unsigned LANES = DW / 8;
  localparam int unsigned LB    = $clog2(LANES);
  localparam int unsigned LW    = (LB == 0) ? 1 : LB;

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] asm_q, asm_d;
  logic [LW-1:0] lane_q, lane_d;  // next lane expected while filling
  logic [AW-1:0] widx_q, widx_d;
  logic [2:0]    bank_q, bank_d;
  logic          err_q, err_d;
  logic [15:0]   sum_q, sum_d, words_q, words_d;

  logic [17:0]   off, dbank_full;
  logic [LW-1:0] lane;
  logic [AW-1:0] windex;
  logic [2:0]    dbank;
  logic          in_win;
  logic          commit;
  logic [DW-1:0] merged, wdata;
  logic [15:0]   bsum;

  assign off        = dl_ad - BASE;
  assign lane       = LW'(off & 18'(LANES - 1));
  assign windex     = AW'(off >> LB);
  assign dbank_full = off >> (AW + LB);
  assign dbank      = dbank_full[2:0];
  assign in_win     = dl_en && (dl_ad >= BASE) && (dbank_full < 18'(NB));

  always_comb begin
    merged = asm_q;
    merged[8*lane +: 8] = dl_dt;
  end

  always_comb begin
    state_d = state_q;
    asm_d   = asm_q;
    lane_d  = lane_q;
    widx_d  = widx_q;
    bank_d  = bank_q;
    err_d   = err_q;
    sum_d   = sum_q;
    words_d = words_q;
    commit  = 1'b0;
    wdata   = merged;
    bsum    = '0;
    if (in_win) begin
      if (lane == '0) begin
        // Lane 0 always (re)starts a word; any partial word is silently dropped.
        if (LANES == 1) begin
          commit  = 1'b1;
          wdata   = DW'(dl_dt);
          state_d = StIdle;
        end else begin
          state_d = StFill;
          asm_d   = DW'(dl_dt);
          lane_d  = LW'(1);
          widx_d  = windex;
          bank_d  = dbank;
        end
      end else if (state_q == StFill) begin
        if (lane == lane_q && windex == widx_q && dbank == bank_q) begin
          if (32'(lane) == LANES - 1) begin
            commit  = 1'b1;
            state_d = StIdle;
          end else begin
            asm_d  = merged;
            lane_d = lane_q + 1'b1;
          end
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
    end
    for (int k = 0; k < LANES; k++) begin
      bsum = bsum + 16'(wdata[8*k +: 8]);
    end
    if (commit) begin
      words_d = words_q + 16'd1;
      sum_d   = sum_q + bsum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      asm_q   <= '0;
      lane_q  <= '0;
      widx_q  <= '0;
      bank_q  <= '0;
      err_q   <= 1'b0;
      sum_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      lane_q  <= lane_d;
      widx_q  <= widx_d;
      bank_q  <= bank_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      words_q <= words_d;
    end
  end

  assign dl_err   = err_q;
  assign dl_sum   = sum_q;
  assign dl_words = words_q;

  // Read path: bank select relative to FIRST, registered with the bank reads.
  logic [2:0]    rb, rb_q;
  logic          valid_q;
  logic [DW-1:0] rd_all [8];

  assign rb = ad[AW+2:AW] - 3'(FIRST);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      rb_q    <= '0;
    end else begin
      valid_q <= (32'(rb) < NB);
      rb_q    <= rb;
    end
  end

  for (genvar b = 0; b < 8; b++) begin : g_bank
    if (b < NB) begin : g_mem
      logic [DW-1:0] mem [2**AW];
      logic [DW-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (commit && !reset && dbank == 3'(b)) begin
          mem[windex] <= wdata;
        end
        rd_q <= mem[ad[AW-1:0]];
      end
      assign rd_all[b] = rd_q;
    end else begin : g_none
      assign rd_all[b] = '0;
    end
  end

  assign dt = valid_q ? rd_all[rb_q] : '0;

endmodule

// File: tb/tb_banked_dlrom.sv
// Bench for banked_dlrom: directed table on a byte-wide instance, hand sequences on 16/32-bit
// instances, then randomized download/read traffic on the 32-bit instance against a model.
module tb_banked_dlrom;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] ad8, ad16, ad32;
  logic [7:0]  dt8;
  logic [15:0] dt16;
  logic [31:0] dt32;
  logic [17:0] dla8, dla16, dla32;
  logic [7:0]  dld8, dld16, dld32;
  logic        en8, en16, en32;
  logic        err8, err16, err32;
  logic [15:0] sum8, sum16, sum32, wrd8, wrd16, wrd32;

  banked_dlrom #(.AW(13), .DW(8), .NB(3), .FIRST(5), .BASE(18'h00000)) u_d8 (
    .clk(clk), .reset(reset), .ad(ad8), .dt(dt8), .dl_ad(dla8), .dl_dt(dld8), .dl_en(en8),
    .dl_err(err8), .dl_sum(sum8), .dl_words(wrd8));
  banked_dlrom #(.AW(13), .DW(16), .NB(3), .FIRST(5), .BASE(18'h10000)) u_d16 (
    .clk(clk), .reset(reset), .ad(ad16), .dt(dt16), .dl_ad(dla16), .dl_dt(dld16), .dl_en(en16),
    .dl_err(err16), .dl_sum(sum16), .dl_words(wrd16));
  banked_dlrom #(.AW(13), .DW(32), .NB(3), .FIRST(5), .BASE(18'h00000)) u_d32 (
    .clk(clk), .reset(reset), .ad(ad32), .dt(dt32), .dl_ad(dla32), .dl_dt(dld32), .dl_en(en32),
    .dl_err(err32), .dl_sum(sum32), .dl_words(wrd32));

  int n_vec = 0;
  int n_bad = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s16(input logic en, input logic [17:0] a, input logic [7:0] d);
    en16 = en; dla16 = a; dld16 = d;
    tick();
  endtask

  task automatic s32(input logic en, input logic [17:0] a, input logic [7:0] d);
    en32 = en; dla32 = a; dld32 = d;
    tick();
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [17:0] dla;
    logic [7:0]  dld;
    logic [15:0] ad;
    logic [7:0]  e_dt;
    logic [15:0] e_words;
    logic [15:0] e_sum;
  } vec_t;

  vec_t tbl [10];

  // Reference model state for the 32-bit instance.
  logic [31:0] mmem [3][4];
  byte unsigned pend [$];
  int          p_bank, p_widx;
  logic        m_err;
  logic [15:0] m_sum, m_words;

  task automatic model_strobe(input int bank, input int widx, input int lane,
                              input logic [7:0] d);
    logic [31:0] w;
    if (bank >= 3) return;
    if (lane == 0) begin
      pend.delete();
      pend.push_back(d);
      p_bank = bank;
      p_widx = widx;
    end else if (pend.size() != 0) begin
      if (lane == pend.size() && bank == p_bank && widx == p_widx) begin
        pend.push_back(d);
        if (pend.size() == 4) begin
          w = {pend[3], pend[2], pend[1], pend[0]};
          mmem[bank][widx] = w;
          m_words = m_words + 16'd1;
          for (int k = 0; k < 4; k++) m_sum = m_sum + 16'(pend[k]);
          pend.delete();
        end
      end else begin
        m_err = 1'b1;
        pend.delete();
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    {en8, en16, en32} = '0;
    {dla8, dla16, dla32} = '0;
    {dld8, dld16, dld32} = '0;
    {ad8, ad16, ad32} = '0;
    tick();
    tick();

    // ---- DW=8 directed table ----
    tbl[0] = '{1'b1, 1'b1, 18'h00000, 8'h77, 16'hA000, 8'h00, 16'd0, 16'h0000};
    tbl[1] = '{1'b0, 1'b1, 18'h00000, 8'h11, 16'h0000, 8'h00, 16'd1, 16'h0011};
    tbl[2] = '{1'b0, 1'b1, 18'h02000, 8'h22, 16'hA000, 8'h11, 16'd2, 16'h0033};
    tbl[3] = '{1'b0, 1'b0, 18'h00000, 8'h00, 16'hC000, 8'h22, 16'd2, 16'h0033};
    tbl[4] = '{1'b0, 1'b0, 18'h00000, 8'h00, 16'h0000, 8'h00, 16'd2, 16'h0033};
    tbl[5] = '{1'b0, 1'b1, 18'h06000, 8'h99, 16'hA000, 8'h11, 16'd2, 16'h0033};
    tbl[6] = '{1'b0, 1'b1, 18'h02005, 8'hAA, 16'h8000, 8'h00, 16'd3, 16'h00DD};
    tbl[7] = '{1'b0, 1'b1, 18'h02005, 8'h55, 16'hC005, 8'hAA, 16'd4, 16'h0132};
    tbl[8] = '{1'b0, 1'b0, 18'h00000, 8'h00, 16'hC005, 8'h55, 16'd4, 16'h0132};
    tbl[9] = '{1'b0, 1'b0, 18'h00000, 8'h00, 16'hA000, 8'h11, 16'd4, 16'h0132};
    for (int i = 0; i < 10; i++) begin
      reset = tbl[i].rst; en8 = tbl[i].en; dla8 = tbl[i].dla; dld8 = tbl[i].dld;
      ad8 = tbl[i].ad;
      tick();
      check($sformatf("d8[%0d].dt", i), 32'(dt8), 32'(tbl[i].e_dt));
      check($sformatf("d8[%0d].words", i), 32'(wrd8), 32'(tbl[i].e_words));
      check($sformatf("d8[%0d].sum", i), 32'(sum8), 32'(tbl[i].e_sum));
      check($sformatf("d8[%0d].err", i), 32'(err8), 32'd0);
    end
    en8 = 1'b0;

    // ---- DW=16, BASE=0x10000 ----
    ad16 = 16'hA000;
    s16(1'b1, 18'h10000, 8'h34);
    s16(1'b1, 18'h10001, 8'h12);
    check("d16.words1", 32'(wrd16), 32'd1);
    check("d16.sum1", 32'(sum16), 32'h46);
    s16(1'b0, 18'h0, 8'h0);
    check("d16.word0", 32'(dt16), 32'h1234);
    s16(1'b1, 18'h10002, 8'h56);
    s16(1'b1, 18'h0FFFF, 8'hAB);   // below BASE mid-word
    s16(1'b1, 18'h10003, 8'h78);
    s16(1'b1, 18'h1C000, 8'h99);   // dbank == NB
    s16(1'b1, 18'h1C001, 8'h98);
    check("d16.err_window", 32'(err16), 32'd0);
    check("d16.words2", 32'(wrd16), 32'd2);
    check("d16.sum2", 32'(sum16), 32'h114);
    ad16 = 16'hA001;
    s16(1'b0, 18'h0, 8'h0);
    check("d16.word1", 32'(dt16), 32'h7856);
    ad16 = 16'hA000;
    s16(1'b1, 18'h10000, 8'hEE);
    reset = 1'b1;
    s16(1'b0, 18'h0, 8'h0);
    check("d16.rst_dt", 32'(dt16), 32'h0);
    check("d16.rst_words", 32'(wrd16), 32'd0);
    check("d16.rst_sum", 32'(sum16), 32'd0);
    reset = 1'b0;
    s16(1'b1, 18'h10001, 8'hDD);
    check("d16.post_words", 32'(wrd16), 32'd0);
    check("d16.post_err", 32'(err16), 32'd0);
    s16(1'b0, 18'h0, 8'h0);
    check("d16.mem_kept", 32'(dt16), 32'h1234);

    // ---- DW=32 lane-order error and restart ----
    ad32 = 16'hA002;
    s32(1'b1, 18'h8, 8'h0D); s32(1'b1, 18'h9, 8'hF0);
    s32(1'b1, 18'hA, 8'hFE); s32(1'b1, 18'hB, 8'hCA);
    check("d32.words1", 32'(wrd32), 32'd1);
    check("d32.sum1", 32'(sum32), 32'h2C5);
    s32(1'b1, 18'h8, 8'h01); s32(1'b1, 18'h9, 8'h02); s32(1'b1, 18'hB, 8'h03);
    check("d32.err_set", 32'(err32), 32'd1);
    check("d32.err_words", 32'(wrd32), 32'd1);
    s32(1'b0, 18'h0, 8'h0);
    check("d32.no_write", dt32, 32'hCAFEF00D);
    s32(1'b1, 18'h8, 8'h01); s32(1'b1, 18'h9, 8'h02);
    s32(1'b1, 18'hA, 8'h03); s32(1'b1, 18'hB, 8'h04);
    check("d32.words2", 32'(wrd32), 32'd2);
    check("d32.sum2", 32'(sum32), 32'h2CF);
    check("d32.err_sticky", 32'(err32), 32'd1);
    s32(1'b0, 18'h0, 8'h0);
    check("d32.word2", dt32, 32'h04030201);
    ad32 = 16'hA003;
    s32(1'b1, 18'hC, 8'hAA); s32(1'b1, 18'hD, 8'hBB);
    s32(1'b1, 18'hC, 8'h11); s32(1'b1, 18'hD, 8'h22);
    s32(1'b1, 18'hE, 8'h33); s32(1'b1, 18'hF, 8'h44);
    check("d32.restart_err", 32'(err32), 32'd1);
    check("d32.restart_sum", 32'(sum32), 32'h379);
    s32(1'b0, 18'h0, 8'h0);
    check("d32.word3", dt32, 32'h44332211);

    // ---- DW=32 randomized against the model ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_err = 1'b0; m_sum = '0; m_words = '0; pend.delete();
    check("d32.rst_err", 32'(err32), 32'd0);
    for (int b = 0; b < 3; b++) begin
      for (int w = 0; w < 4; w++) begin
        logic [31:0] v;
        v = $urandom;
        for (int l = 0; l < 4; l++) begin
          model_strobe(b, w, l, v[8*l +: 8]);
          s32(1'b1, 18'((b << 15) | (w << 2) | l), v[8*l +: 8]);
        end
      end
    end
    en32 = 1'b0;
    check("d32.init_words", 32'(wrd32), 32'(m_words));
    for (int i = 0; i < 3000; i++) begin
      int fld, rw, bank, widx, lane, rb;
      logic [7:0]  d;
      logic [31:0] exp_dt;
      fld = int'($urandom % 8);
      rw  = int'($urandom % 4);
      ad32 = 16'((fld << 13) | rw);
      rb = (fld - 5) & 7;
      exp_dt = (rb < 3) ? mmem[rb][rw] : 32'h0;
      if (pend.size() != 0 && $urandom % 10 < 7) begin
        bank = p_bank; widx = p_widx; lane = pend.size();
      end else begin
        bank = int'($urandom % 4);
        widx = int'($urandom % 4);
        lane = ($urandom % 2 == 0) ? 0 : int'($urandom % 4);
      end
      d = 8'($urandom);
      en32 = ($urandom % 5) != 0;
      dla32 = 18'((bank << 15) | (widx << 2) | lane);
      dld32 = d;
      if (en32) model_strobe(bank, widx, lane, d);
      tick();
      check($sformatf("rnd[%0d].dt", i), dt32, exp_dt);
      check($sformatf("rnd[%0d].cnt", i), {err32, sum32[14:0], wrd32},
            {m_err, m_sum[14:0], m_words});
      if (sum32[15] !== m_sum[15]) begin
        n_bad++;
        $display("FAIL rnd[%0d].sum15: got %b expected %b", i, sum32[15], m_sum[15]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
